// File: rtl/bpm_digit_entry.sv
// Keypad digit entry for the metronome: accumulates up to three decimal digits,
// range-checks the result on enter and commits it as the 9-bit BPM value.
module bpm_digit_entry #(
    parameter int MIN_VALUE      = 30,
    parameter int MAX_VALUE      = 299,
    parameter int DEFAULT_VALUE  = 120,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       enter,
    input  logic       cancel,
    output logic [8:0] value,
    output logic       value_valid,
    output logic       entry_active,
    output logic [1:0] digits_entered,
    output logic [8:0] entry_value,
    output logic       error
);

    localparam int TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [TW-1:0] TO_LAST   = TW'(TO_LAST_I);
    localparam logic [9:0]    MIN_V     = 10'(MIN_VALUE);
    localparam logic [9:0]    MAX_V     = 10'(MAX_VALUE);
    localparam logic [8:0]    DEFAULT_V = 9'(DEFAULT_VALUE);
    localparam logic          TO_EN     = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    acc_q, acc_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [8:0]    value_q, value_d;
    logic          vv_q, vv_d;
    logic          err_q, err_d;
    logic [TW-1:0] to_q, to_d;

    logic [9:0] acc_next;
    logic       digit_ok;
    logic       any_strobe;
    logic       timeout_hit;
    logic       in_range;

    // acc*10 + digit as two shifts and an add; 999 is the largest reachable value
    assign acc_next    = (acc_q << 3) + (acc_q << 1) + {6'd0, digit};
    assign digit_ok    = (digit <= 4'd9);
    assign any_strobe  = digit_valid | enter | cancel;
    assign timeout_hit = TO_EN && (to_q == TO_LAST) && !any_strobe;
    assign in_range    = (acc_q >= MIN_V) && (acc_q <= MAX_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            value_q <= DEFAULT_V;
            vv_q    <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            vv_q    <= vv_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        vv_d    = 1'b0;
        err_d   = 1'b0;
        to_d    = '0;

        case (state_q)
            S_IDLE: begin
                // cancel/enter outrank a same-cycle digit, so the digit is dropped
                if (digit_valid && !cancel && !enter) begin
                    if (digit_ok) begin
                        acc_d   = {6'd0, digit};
                        cnt_d   = 2'd1;
                        state_d = S_ENTRY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_ENTRY: begin
                to_d = to_q + TW'(1);
                if (cancel || timeout_hit) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    to_d    = '0;
                    state_d = S_IDLE;
                end else if (enter) begin
                    to_d    = '0;
                    state_d = S_CHECK;
                end else if (digit_valid) begin
                    to_d = '0;
                    if (digit_ok && cnt_q != 2'd3) begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + 2'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_CHECK: begin
                if (in_range) begin
                    value_d = acc_q[8:0];
                    vv_d    = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign value          = value_q;
    assign value_valid    = vv_q;
    assign error          = err_q;
    assign digits_entered = cnt_q;
    assign entry_active   = (state_q != S_IDLE);
    assign entry_value    = (acc_q > 10'd511) ? 9'd511 : acc_q[8:0];

endmodule

// File: tb/tb_bpm_digit_entry.sv
// Scoreboard bench for bpm_digit_entry: expected commit/error events are queued
// when enter or a bad digit is driven, and popped when a pulse appears.
module tb_bpm_digit_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       enter = 1'b0;
    logic       cancel = 1'b0;
    logic [8:0] value;
    logic       value_valid;
    logic       entry_active;
    logic [1:0] digits_entered;
    logic [8:0] entry_value;
    logic       error;

    typedef struct packed {
        logic       is_err;
        logic [8:0] val;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] exp_value = 9'd120;

    bpm_digit_entry #(
        .MIN_VALUE(30), .MAX_VALUE(299), .DEFAULT_VALUE(120), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
        .enter(enter), .cancel(cancel), .value(value), .value_valid(value_valid),
        .entry_active(entry_active), .digits_entered(digits_entered),
        .entry_value(entry_value), .error(error)
    );

    always #5 clk = ~clk;

    // Pulse monitor: every value_valid/error pulse must match the queue head
    always @(negedge clk) begin
        if (value_valid || error) begin
            n_tests++;
            if (value_valid && error) begin
                n_fail++;
                $display("FAIL pulse_overlap: value_valid=%b error=%b, expected never both", value_valid, error);
            end else if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: value_valid=%b error=%b value=%0d, expected no pulse",
                         value_valid, error, value);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (error !== e.is_err || value !== e.val) begin
                    n_fail++;
                    $display("FAIL pulse_event: error=%b value=%0d, expected error=%b value=%0d",
                             error, value, e.is_err, e.val);
                end
            end
        end
    end

    task automatic step(input logic dv, input logic [3:0] d, input logic en, input logic cn);
        digit_valid = dv; digit = d; enter = en; cancel = cn;
        @(posedge clk); #1;
        digit_valid = 1'b0; digit = 4'd0; enter = 1'b0; cancel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20) begin @(posedge clk); #1; k++; end
        idle(2);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d events outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        n_tests++;
        if (value !== 9'd120 || value_valid !== 1'b0 || error !== 1'b0 || entry_active !== 1'b0 ||
            digits_entered !== 2'd0 || entry_value !== 9'd0) begin
            n_fail++;
            $display("FAIL reset: value=%0d vv=%b err=%b act=%b de=%0d ev=%0d, expected 120 0 0 0 0 0",
                     value, value_valid, error, entry_active, digits_entered, entry_value);
        end
        rst = 1'b0;
        exp_value = 9'd120;
        idle(1);
    endtask

    task automatic test_commit;
        step(1, 4'd1, 0, 0);
        n_tests++;
        if (entry_value !== 9'd1 || digits_entered !== 2'd1 || entry_active !== 1'b1) begin
            n_fail++;
            $display("FAIL commit_d1: ev=%0d de=%0d act=%b, expected 1 1 1", entry_value, digits_entered, entry_active);
        end
        step(1, 4'd4, 0, 0);
        n_tests++;
        if (entry_value !== 9'd14 || digits_entered !== 2'd2) begin
            n_fail++;
            $display("FAIL commit_d2: ev=%0d de=%0d, expected 14 2", entry_value, digits_entered);
        end
        step(1, 4'd0, 0, 0);
        n_tests++;
        if (entry_value !== 9'd140 || digits_entered !== 2'd3) begin
            n_fail++;
            $display("FAIL commit_d3: ev=%0d de=%0d, expected 140 3", entry_value, digits_entered);
        end
        sb.push_back('{is_err: 1'b0, val: 9'd140});
        exp_value = 9'd140;
        step(0, 4'd0, 1, 0);
        n_tests++;
        if (entry_active !== 1'b1 || value !== 9'd120) begin
            n_fail++;
            $display("FAIL commit_check: act=%b value=%0d, expected 1 120", entry_active, value);
        end
        idle(1);
        n_tests++;
        if (value !== 9'd140 || digits_entered !== 2'd0 || entry_active !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_done: value=%0d de=%0d act=%b, expected 140 0 0", value, digits_entered, entry_active);
        end
        drain("commit");
    endtask

    task automatic test_out_of_range;
        step(1, 4'd3, 0, 0); step(1, 4'd5, 0, 0); step(1, 4'd0, 0, 0);
        sb.push_back('{is_err: 1'b1, val: exp_value});
        step(0, 4'd0, 1, 0);
        idle(1);
        n_tests++;
        if (value !== exp_value || entry_active !== 1'b0) begin
            n_fail++;
            $display("FAIL over_max: value=%0d act=%b, expected %0d 0", value, entry_active, exp_value);
        end
        step(1, 4'd2, 0, 0); step(1, 4'd5, 0, 0);
        sb.push_back('{is_err: 1'b1, val: exp_value});
        step(0, 4'd0, 1, 0);
        idle(1);
        step(1, 4'd3, 0, 0); step(1, 4'd0, 0, 0);
        sb.push_back('{is_err: 1'b0, val: 9'd30});
        exp_value = 9'd30;
        step(0, 4'd0, 1, 0);
        idle(1);
        n_tests++;
        if (value !== 9'd30) begin
            n_fail++;
            $display("FAIL min_commit: value=%0d, expected 30", value);
        end
        drain("range");
    endtask

    task automatic test_boundary;
        step(1, 4'd2, 0, 0); step(1, 4'd9, 0, 0); step(1, 4'd9, 0, 0);
        sb.push_back('{is_err: 1'b0, val: 9'd299});
        exp_value = 9'd299;
        step(0, 4'd0, 1, 0);
        idle(1);
        step(1, 4'd9, 0, 0); step(1, 4'd9, 0, 0); step(1, 4'd9, 0, 0);
        n_tests++;
        if (entry_value !== 9'd511) begin
            n_fail++;
            $display("FAIL saturate: ev=%0d, expected 511", entry_value);
        end
        sb.push_back('{is_err: 1'b1, val: exp_value});
        step(0, 4'd0, 1, 0);
        idle(1);
        n_tests++;
        if (value !== 9'd299) begin
            n_fail++;
            $display("FAIL max_hold: value=%0d, expected 299", value);
        end
        drain("boundary");
    endtask

    task automatic test_fourth_digit;
        step(1, 4'd1, 0, 0); step(1, 4'd2, 0, 0); step(1, 4'd3, 0, 0);
        sb.push_back('{is_err: 1'b1, val: exp_value});
        step(1, 4'd4, 0, 0);
        n_tests++;
        if (digits_entered !== 2'd3 || entry_value !== 9'd123) begin
            n_fail++;
            $display("FAIL fourth_digit: de=%0d ev=%0d, expected 3 123", digits_entered, entry_value);
        end
        sb.push_back('{is_err: 1'b0, val: 9'd123});
        exp_value = 9'd123;
        step(0, 4'd0, 1, 0);
        idle(1);
        n_tests++;
        if (value !== 9'd123) begin
            n_fail++;
            $display("FAIL fourth_commit: value=%0d, expected 123", value);
        end
        drain("fourth");
    endtask

    task automatic test_cancel;
        step(1, 4'd9, 0, 1);
        n_tests++;
        if (entry_active !== 1'b0 || digits_entered !== 2'd0 || value !== exp_value) begin
            n_fail++;
            $display("FAIL cancel_idle: act=%b de=%0d value=%0d, expected 0 0 %0d",
                     entry_active, digits_entered, value, exp_value);
        end
        step(1, 4'd5, 0, 0);
        step(1, 4'd9, 0, 1);
        n_tests++;
        if (entry_active !== 1'b0 || digits_entered !== 2'd0 || entry_value !== 9'd0) begin
            n_fail++;
            $display("FAIL cancel_entry: act=%b de=%0d ev=%0d, expected 0 0 0",
                     entry_active, digits_entered, entry_value);
        end
        sb.push_back('{is_err: 1'b1, val: exp_value});
        step(1, 4'hA, 0, 0);
        n_tests++;
        if (entry_active !== 1'b0 || digits_entered !== 2'd0) begin
            n_fail++;
            $display("FAIL bad_digit_idle: act=%b de=%0d, expected 0 0", entry_active, digits_entered);
        end
        drain("cancel");
    endtask

    task automatic test_timeout;
        step(1, 4'd2, 0, 0);
        idle(15);
        n_tests++;
        if (entry_active !== 1'b1 || digits_entered !== 2'd1) begin
            n_fail++;
            $display("FAIL timeout_early: act=%b de=%0d, expected 1 1", entry_active, digits_entered);
        end
        idle(1);
        n_tests++;
        if (entry_active !== 1'b0 || digits_entered !== 2'd0 || value !== exp_value) begin
            n_fail++;
            $display("FAIL timeout: act=%b de=%0d value=%0d, expected 0 0 %0d",
                     entry_active, digits_entered, value, exp_value);
        end
        drain("timeout");
    endtask

    task automatic test_reset_mid_entry;
        step(1, 4'd1, 0, 0); step(1, 4'd5, 0, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_value = 9'd120;
        n_tests++;
        if (value !== 9'd120 || value_valid !== 1'b0 || error !== 1'b0 || entry_active !== 1'b0 ||
            digits_entered !== 2'd0 || entry_value !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_mid: value=%0d vv=%b err=%b act=%b de=%0d ev=%0d, expected 120 0 0 0 0 0",
                     value, value_valid, error, entry_active, digits_entered, entry_value);
        end
        drain("reset_mid");
    endtask

    initial begin
        test_reset;
        test_commit;
        test_out_of_range;
        test_boundary;
        test_fourth_digit;
        test_cancel;
        test_timeout;
        test_reset_mid_entry;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
